// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient path: filter geometry and the
// coefficient loader state encoding.
// Optional feature macro used by the loader: FIR_COEFF_LOADER_CHECKSUM_EN.
package fir_pkg;

    localparam int TAPS        = 128;
    localparam int COEFF_WIDTH = 16;
    localparam int ADDR_WIDTH  = $clog2(TAPS);

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_IDLE   = 3'd0;
    localparam loader_state_t ST_HI     = 3'd1;
    localparam loader_state_t ST_LO     = 3'd2;
    localparam loader_state_t ST_WR     = 3'd3;
    localparam loader_state_t ST_CHK_HI = 3'd4;
    localparam loader_state_t ST_CHK_LO = 3'd5;
    localparam loader_state_t ST_FIN    = 3'd6;

endpackage

// File: rtl/fir_coeff_checksum.sv
// Running modulo-2^16 sum of the coefficient words written during a load,
// compared against the host-supplied trailer. Only instantiated when
// FIR_COEFF_LOADER_CHECKSUM_EN is defined.
module fir_coeff_checksum
    import fir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   add_en,
    input  logic [COEFF_WIDTH-1:0] add_val,
    input  logic [15:0]            cmp_val,
    output logic                   match
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    // Next sum: clear at load start, accumulate on each committed write
    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + add_val;
        end
    end

    // Sum register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match = (sum_q == cmp_val);

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: takes a big-endian byte stream over valid/ready,
// assembles 16-bit words and writes them to coefficient addresses 0..TAPS-1.
// Optional checksum trailer: FIR_COEFF_LOADER_CHECKSUM_EN.
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready.
// s_ready is high only in HI/LO (and CHK_HI/CHK_LO) and never while
// load_abort is asserted, so an abort always wins over a pending byte.
module fir_coeff_loader
    import fir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_start,
    input  logic                   load_abort,
    input  logic [7:0]             s_byte,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   coeff_wr_en,
    output logic [ADDR_WIDTH-1:0]  coeff_addr,
    output logic [COEFF_WIDTH-1:0] coeff_data,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   load_error,
    output loader_state_t          dbg_state
);

    loader_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [7:0]             hi_q,    hi_d;
    logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
    logic [COEFF_WIDTH-1:0] data_q,  data_d;
    logic                   err_q,   err_d;

    logic accept;
    logic abort_act;
    logic start_act;
    logic last_word;

    assign accept    = s_valid && s_ready;
    assign abort_act = load_abort && (state_q != ST_IDLE);
    assign start_act = load_start && !load_abort && (state_q == ST_IDLE);
    assign last_word = (cnt_q == ADDR_WIDTH'(TAPS - 1));

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    logic chk_match;

    fir_coeff_checksum u_checksum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_act),
        .add_en  ((state_q == ST_WR) && !abort_act),
        .add_val (data_q),
        .cmp_val ({hi_q, s_byte}),
        .match   (chk_match)
    );
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; an abort in any busy state returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_act) state_d = ST_HI;
            ST_HI:   if (accept)    state_d = ST_LO;
            ST_LO:   if (accept)    state_d = ST_WR;
            ST_WR: begin
                if (!last_word) begin
                    state_d = ST_HI;
                end else begin
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                    state_d = ST_CHK_HI;
`else
                    state_d = ST_FIN;
`endif
                end
            end
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            ST_CHK_HI: if (accept) state_d = ST_CHK_LO;
            ST_CHK_LO: if (accept) state_d = ST_FIN;
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_act) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath next values: byte capture, word assembly, counter, error flag
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        addr_d = addr_q;
        data_d = data_q;
        err_d  = err_q;
        if (start_act) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
        if ((state_q == ST_HI) && accept) begin
            hi_d = s_byte;
        end
        if ((state_q == ST_LO) && accept) begin
            addr_d = cnt_q;
            data_d = {hi_q, s_byte};
        end
        if ((state_q == ST_WR) && !abort_act) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        if ((state_q == ST_CHK_HI) && accept) begin
            hi_d = s_byte;
        end
        if ((state_q == ST_CHK_LO) && accept && !chk_match) begin
            err_d = 1'b1;
        end
`endif
        if (abort_act) begin
            err_d = 1'b1;
        end
    end

    // Outputs decoded from the registered state; abort masks strobes at once
    always_comb begin
        s_ready     = ((state_q == ST_HI) || (state_q == ST_LO) ||
                       (state_q == ST_CHK_HI) || (state_q == ST_CHK_LO)) && !load_abort;
        coeff_wr_en = (state_q == ST_WR) && !load_abort;
        load_busy   = (state_q != ST_IDLE);
        load_done   = (state_q == ST_FIN) && !load_abort;
        coeff_addr  = addr_q;
        coeff_data  = data_q;
        load_error  = err_q;
        dbg_state   = state_q;
    end

endmodule
